// File: rtl/logic_op_pkg.sv
// Shared op-code constants and arbiter state encoding for the logic-op arbiter slice.
package logic_op_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise op evaluator shared by both requesters.
// XOR/NOR are only built when LOGIC_OP_ARB_XOR_NOR_EN is defined; otherwise they flag err_o.
module logic_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
`ifdef LOGIC_OP_ARB_XOR_NOR_EN
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOR: result_o = ~(a_i | b_i);
`else
      OP_XOR, OP_NOR: err_o = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin front end to a single registered logic unit.
// Optional XOR/NOR support is selected with LOGIC_OP_ARB_XOR_NOR_EN (see logic_unit).
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             resp_err
);

  state_e           state_q, state_d;
  logic             lastGrant_q, lastGrant_d;
  logic [WIDTH-1:0] respData_q, respData_d;
  logic             respId_q, respId_d;
  logic             respErr_q, respErr_d;

  logic             accept;
  logic             grantId;
  logic             transfer;
  logic [1:0]       selOp;
  logic [WIDTH-1:0] selA, selB;
  logic [WIDTH-1:0] unitResult;
  logic             unitErr;

  // Reset masks accept so no handshake can complete in a reset cycle.
  always_comb begin
    accept = rst_n && ((state_q == ST_IDLE) || resp_ready);
    if (req0_valid && req1_valid) begin
      grantId = ~lastGrant_q;
    end else begin
      grantId = req1_valid;
    end
    req0_ready = accept && req0_valid && !grantId;
    req1_ready = accept && req1_valid && grantId;
    transfer   = req0_ready || req1_ready;
    selOp      = grantId ? req1_op : req0_op;
    selA       = grantId ? req1_a  : req0_a;
    selB       = grantId ? req1_b  : req0_b;
  end

  logic_unit #(
    .WIDTH(WIDTH)
  ) u_logic_unit (
    .op_i     (selOp),
    .a_i      (selA),
    .b_i      (selB),
    .result_o (unitResult),
    .err_o    (unitErr)
  );

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    respData_d  = respData_q;
    respId_d    = respId_q;
    respErr_d   = respErr_q;
    case (state_q)
      ST_IDLE: if (transfer) state_d = ST_HOLD;
      ST_HOLD: if (resp_ready && !transfer) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (transfer) begin
      lastGrant_d = grantId;
      respData_d  = unitResult;
      respId_d    = grantId;
      respErr_d   = unitErr;
    end
  end

  // lastGrant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lastGrant_q <= 1'b1;
      respData_q  <= '0;
      respId_q    <= 1'b0;
      respErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      respData_q  <= respData_d;
      respId_q    <= respId_d;
      respErr_q   <= respErr_d;
    end
  end

  assign resp_valid = (state_q == ST_HOLD);
  assign resp_data  = respData_q;
  assign resp_id    = respId_q;
  assign resp_err   = respErr_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_logic_op_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id, resp_err;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  logic_op_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic rr);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    resp_ready = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] d, input logic id, input logic err);
    exp_t e;
    e.data = d; e.id = id; e.err = err;
    expQ.push_back(e);
  endtask

  // Every accepted response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_resp actual=%h expected=none", resp_data);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sb_resp_data", resp_data, e.data);
        checkOutput("sb_resp_id", {31'd0, resp_id}, {31'd0, e.id});
        checkOutput("sb_resp_err", {31'd0, resp_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t dummy;
    dummy = '0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    tick();

    // Reset state and readys forced low while in reset.
    applyStimulus(1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 2'b01, 32'h1, 32'h1, 1'b1);
    #1;
    checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'h0);
    tick();
    checkOutput("rst_hold_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_id", {31'd0, resp_id}, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);

    // Single AND from requester 0.
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    #1;
    checkOutput("and_req0_ready", {31'd0, req0_ready}, 32'd1);
    pushExp(32'h0F0F0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    #1;
    checkOutput("and_resp_valid", {31'd0, resp_valid}, 32'd1);
    tick();

    // OR from requester 1 held under back-pressure, then pending req0 accepted on release.
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b01, 32'h00000001, 32'h80000000, 1'b0);
    #1;
    checkOutput("or_req1_ready", {31'd0, req1_ready}, 32'd1);
    checkOutput("or_req0_ready", {31'd0, req0_ready}, 32'd0);
    pushExp(32'h80000001, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b00, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("stall_resp_data", resp_data, 32'h80000001);
      checkOutput("stall_resp_id", {31'd0, resp_id}, 32'd1);
      checkOutput("stall_req0_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checkOutput("release_req0_ready", {31'd0, req0_ready}, 32'd1);
    pushExp(32'hA5A5A5A5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    tick();

    // XOR then NOR, result depends on build configuration.
    applyStimulus(1'b1, 2'b10, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    #1;
    checkOutput("xor_req0_ready", {31'd0, req0_ready}, 32'd1);
`ifdef LOGIC_OP_ARB_XOR_NOR_EN
    pushExp(32'hFFFF0000, 1'b0, 1'b0);
`else
    pushExp(32'h00000000, 1'b0, 1'b1);
`endif
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b11, 32'hF0F0F0F0, 32'h0F0F0000, 1'b1);
    #1;
    checkOutput("nor_req1_ready", {31'd0, req1_ready}, 32'd1);
`ifdef LOGIC_OP_ARB_XOR_NOR_EN
    pushExp(32'h00000F0F, 1'b1, 1'b0);
`else
    pushExp(32'h00000000, 1'b1, 1'b1);
`endif
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    tick();
    tick();

    // Reset while holding a result discards it.
    applyStimulus(1'b1, 2'b00, 32'h12345678, 32'hFFFF0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("prereset_resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("prereset_resp_data", resp_data, 32'h12340000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("midhold_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("midhold_rst_resp_data", resp_data, 32'h0);
    checkOutput("midhold_rst_resp_id", {31'd0, resp_id}, 32'd0);
    checkOutput("midhold_rst_resp_err", {31'd0, resp_err}, 32'd0);

    // Continuous contention alternates starting with requester 0.
    applyStimulus(1'b1, 2'b00, 32'h0000FFFF, 32'h12345678, 1'b1, 2'b01, 32'h00F000F0, 32'h0F000F00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = k[0];
      #1;
      checkOutput("rr_req0_ready", {31'd0, req0_ready}, {31'd0, ~g});
      checkOutput("rr_req1_ready", {31'd0, req1_ready}, {31'd0, g});
      pushExp(g ? 32'h0FF00FF0 : 32'h00005678, g, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    tick();
    tick();

    checkOutput("sb_drained", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_op_arbiter.md
LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid, req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready, req1_ready  output  1 each  requester N's operation accepted this cycle.
REQ-006 req0_op, req1_op  input  2 each  op code: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-008 resp_valid  output  1  result held for consumer.
REQ-009 resp_ready  input  1  consumer takes result.
REQ-010 resp_data  output  WIDTH  registered result.
REQ-011 resp_id  output  1  requester that owns resp_data.
REQ-012 resp_err  output  1  op code unsupported in this build.

Function
REQ-013 Single shared logic unit; states IDLE (no result held) and HOLD (result held, resp_valid=1).
REQ-014 Accept condition: state IDLE, or state HOLD with resp_ready=1 (back-to-back, one op per cycle).
REQ-015 When accept holds and exactly one reqN_valid=1, that requester is granted.
REQ-016 When both valid, round-robin: grant the requester not granted last; last_grant updates only on an accepted transfer.
REQ-017 reqN_ready=1 only for the granted requester while accept holds; never both high; combinational from valids, state, resp_ready.
REQ-018 Transfer occurs when reqN_valid and reqN_ready both 1; resp_data/resp_id/resp_err load at that clock edge; latency one cycle.
REQ-019 Transitions: IDLE->HOLD on transfer; HOLD->HOLD on resp_ready with new transfer; HOLD->IDLE on resp_ready without transfer; otherwise state holds.
REQ-020 In HOLD without resp_ready, resp_data, resp_id and resp_err stay stable; new requests stall (ready=0).
REQ-021 Operations bitwise over WIDTH bits; no carry, no width extension.
REQ-022 resp_data/resp_id/resp_err keep last values in IDLE; consumer qualifies with resp_valid.
REQ-023 Requester may drop valid without a transfer; no state change results.

Reset
REQ-024 rst_n=0 at a clock edge: state IDLE, resp_valid 0, resp_data 0, resp_id 0, resp_err 0, last_grant 1 (requester 0 wins first contention).
REQ-025 While rst_n=0, req0_ready and req1_ready are 0.
REQ-026 Reset mid-HOLD discards the held result; no transfer completes in a reset cycle.

Configuration
REQ-027 Macro LOGIC_OP_ARB_XOR_NOR_EN defined: XOR and NOR computed; resp_err always 0.
REQ-028 Macro undefined: op 10/11 accepted normally, resp_data=0, resp_err=1; AND/OR unaffected; no XOR/NOR logic synthesized.

Structure
REQ-029 Shared package logic_op_pkg holds op-code constants (OP_AND, OP_OR, OP_XOR, OP_NOR) and the state encoding (ST_IDLE, ST_HOLD).
REQ-030 Sub-module logic_unit: combinational WIDTH-bit op evaluator (op, a, b -> result, err), instanced once after the grant mux.
REQ-031 Grant/round-robin logic, state register and output register reside in logic_op_arbiter.

Verification
REQ-032 Reset then req0 AND a=FFFF0000 b=0F0F0F0F, resp_ready=1 -> next cycle resp_valid=1, resp_data=0F0F0000, resp_id=0.
REQ-033 Both valid every cycle, resp_ready=1 -> grants alternate 0,1,0,1, one transfer per cycle, ready never both high.
REQ-034 req1 OR a=00000001 b=80000000, resp_ready=0 for 3 cycles -> resp_data=80000001 stable, both ready=0; on resp_ready=1 a pending req0 is accepted same cycle.
REQ-035 req0 op=10 a=FFFFFFFF b=0000FFFF -> with macro FFFF0000, err 0; without macro 00000000, err 1.
REQ-036 rst_n=0 while in HOLD -> next cycle resp_valid=0, outputs 0, then req0 wins first contention.
